// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the multicycle ALU.
//   - opcode encodings (3 bits)
//   - FSM state encoding (1 bit)
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/alu_mul.sv
// alu_mul: N-step unsigned shift-add multiplier.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_i        : capture operands, clear the accumulator
//   step_i        : consume one multiplier bit (LSB first)
//   a_i, b_i      : multiplicand, multiplier (N bits)
//   prod_o        : 2N-bit product, valid after N steps
// Only instantiated by alu when ALU_MUL_EN is defined.
module alu_mul #(
  parameter int N = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] prod_o
);

  logic [N-1:0] mcand_q, mcand_d;
  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] lo_q, lo_d;
  logic [N:0]   sum;

  // lo starts as the multiplier and is shifted out from the bottom while
  // product bits shift in from hi; after N steps {hi,lo} is the product.
  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    if (load_i) begin
      mcand_d = a_i;
      hi_d    = '0;
      lo_d    = b_i;
    end else if (step_i) begin
      hi_d = sum[N:1];
      lo_d = {sum[0], lo_q[N-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign prod_o = {hi_q, lo_q};

endmodule

// File: rtl/alu.sv
// alu: multicycle N-bit ALU started by a one-cycle strobe.
// Every operation takes exactly N clock edges after the start edge; the
// result then holds until the next start or reset.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (priority over inp)
//   inp       : start strobe, accepted only in IDLE
//   opcode    : operation select (see alu_pkg), latched at start
//   a, b      : operands, latched at start
//   y_ext     : multiply high word, else 0
//   y         : primary result
//   ovf       : carry (ADD) / borrow (SUB), else 0
// Build option: define ALU_MUL_EN to implement MUL; otherwise opcode 111
// runs N cycles and returns all zeros.
module alu
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inp,
  input  logic [2:0]   opcode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y_ext,
  output logic [N-1:0] y,
  output logic         ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  y_q, y_d;
  logic          ovf_q, ovf_d;
  logic          carry_q, carry_d;

  logic start, run, last, first, is_sub;
  logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  assign start  = (state_q == ST_IDLE) && inp;
  assign run    = (state_q == ST_RUN);
  assign last   = (cnt_q == CNT_LAST);
  assign first  = (cnt_q == '0);
  assign is_sub = (op_q == OP_SUB);

  // Bit-serial full adder. Subtraction is a + ~b + 1; the +1 is injected as
  // carry-in on step 0 since the carry flop is cleared at start.
  assign fa_a    = a_q[cnt_q];
  assign fa_b    = b_q[cnt_q] ^ is_sub;
  assign fa_cin  = carry_q | (is_sub & first);
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;
    if (start) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      op_d    = opcode;
      a_d     = a;
      b_d     = b;
      ovf_d   = 1'b0;
      carry_d = 1'b0;
      y_d     = ((opcode == OP_SHL) || (opcode == OP_SHR)) ? a : '0;
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      case (op_q)
        OP_ADD, OP_SUB: begin
          y_d[cnt_q] = fa_sum;
          carry_d    = fa_cout;
          if (last) ovf_d = is_sub ? ~fa_cout : fa_cout;
        end
        OP_AND: if (first) y_d = a_q & b_q;
        OP_OR:  if (first) y_d = a_q | b_q;
        OP_NOT: if (first) y_d = ~a_q;
        OP_SHL: y_d = y_q << 1;
        OP_SHR: y_d = y_q >> 1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
    end
  end

  assign ovf = ovf_q;

`ifdef ALU_MUL_EN
  logic [2*N-1:0] prod;
  logic           mul_show;

  alu_mul #(.N(N)) u_mul (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (start),
    .step_i (run && (op_q == OP_MUL)),
    .a_i    (a),
    .b_i    (b),
    .prod_o (prod)
  );

  // The product register holds partial sums while running; expose it only
  // once the MUL has completed so outputs read 0 during the run.
  assign mul_show = (state_q == ST_IDLE) && (op_q == OP_MUL);
  assign y        = mul_show ? prod[N-1:0]   : y_q;
  assign y_ext    = mul_show ? prod[2*N-1:N] : '0;
`else
  assign y     = y_q;
  assign y_ext = '0;
`endif

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inp = 1'b0;
  logic [2:0]   opcode = 3'b000;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] y_ext;
  logic [N-1:0] y;
  logic         ovf;

  int n_chk  = 0;
  int n_pass = 0;

  alu #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .inp    (inp),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .y_ext  (y_ext),
    .y      (y),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Arithmetic reference for the final result of one operation.
  function automatic void model(input int op, input int ua, input int ub,
                                output int ey, output int eyx, output int eo);
    int p;
    ey = 0; eyx = 0; eo = 0;
    case (op)
      0: begin p = ua + ub; ey = p & MASK; eo = (p >> N) & 1; end
      1: begin ey = (ua - ub) & MASK; eo = (ua < ub) ? 1 : 0; end
      2: ey = ua & ub;
      3: ey = ua | ub;
      4: ey = (~ua) & MASK;
      5: ey = (ua << N) & MASK;
      6: ey = ua >> N;
      default: begin
`ifdef ALU_MUL_EN
        p = ua * ub; ey = p & MASK; eyx = (p >> N) & MASK;
`endif
      end
    endcase
  endfunction

  // Start one op, optionally pulse inp with another opcode at edge gk (1..N),
  // check shift intermediates each step and the final triple after edge N.
  task automatic run_op(input int op, input int ua, input int ub, input int gk,
                        input string tag);
    int ey, eyx, eo, es;
    model(op, ua, ub, ey, eyx, eo);
    @(negedge clk);
    inp = 1'b1; opcode = 3'(op); a = N'(ua); b = N'(ub);
    @(negedge clk);
    inp = 1'b0; opcode = 3'($urandom); a = N'($urandom); b = N'($urandom);
    for (int k = 1; k <= N; k++) begin
      if (k == gk) begin
        inp = 1'b1; opcode = 3'(op ^ 3);
      end else inp = 1'b0;
      @(negedge clk);
      if (op == 5 || op == 6) begin
        es = (op == 5) ? ((ua << k) & MASK) : (ua >> k);
        check($sformatf("%s_step%0d", tag, k), int'(y), es);
      end
    end
    inp = 1'b0;
    check({tag, "_y"}, int'(y), ey);
    check({tag, "_yext"}, int'(y_ext), eyx);
    check({tag, "_ovf"}, int'(ovf), eo);
  endtask

  initial begin
    int ey, eyx, eo, yh;
    repeat (2) @(negedge clk);
    check("rst_y", int'(y), 0);
    check("rst_yext", int'(y_ext), 0);
    check("rst_ovf", int'(ovf), 0);

    // reset has priority over a start strobe
    inp = 1'b1; opcode = 3'd4; a = 4'b0101;
    @(negedge clk);
    rst = 1'b0; inp = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_prio_y", int'(y), 0);

    // directed scenarios, a=0101 b=1101
    run_op(0, 5, 13, 0, "add");
    check("add_const_y", int'(y), 2);
    check("add_const_ovf", int'(ovf), 1);
    run_op(1, 5, 13, 0, "sub");
    check("sub_const_y", int'(y), 8);
    run_op(2, 5, 13, 0, "and");
    run_op(3, 5, 13, 0, "or");
    run_op(4, 5, 13, 0, "not");
    check("not_const_y", int'(y), 10);
    run_op(5, 5, 13, 0, "shl");
    run_op(6, 5, 13, 0, "shr");
    run_op(7, 5, 13, 0, "mul");

    // outputs hold in IDLE
    yh = int'(y);
    repeat (3) @(negedge clk);
    check("hold_y", int'(y), yh);

    // strobe during RUN is ignored
    run_op(0, 5, 13, 2, "glitch_add");
    run_op(5, 5, 13, 1, "glitch_shl");

    // reset at step 2 of MUL, then an ADD right after
    @(negedge clk);
    inp = 1'b1; opcode = 3'd7; a = 4'b0101; b = 4'b1101;
    @(negedge clk);
    inp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_y", int'(y), 0);
    check("abort_yext", int'(y_ext), 0);
    check("abort_ovf", int'(ovf), 0);
    run_op(0, 5, 13, 0, "post_abort_add");

    // inp held high: one start, then a restart right after completion
    @(negedge clk);
    inp = 1'b1; opcode = 3'd0; a = 4'b0101; b = 4'b1101;
    repeat (N + 1) @(negedge clk);
    check("held_y", int'(y), 2);
    check("held_ovf", int'(ovf), 1);
    @(negedge clk);
    check("held_restart_ovf", int'(ovf), 0);
    check("held_restart_y", int'(y), 0);
    inp = 1'b0;
    repeat (N) @(negedge clk);
    check("held_second_y", int'(y), 2);

    // boundaries
    run_op(0, 15, 15, 0, "add_max");
    run_op(1, 0, 0, 0, "sub_zero");
    run_op(1, 3, 4, 0, "sub_borrow");
    run_op(7, 15, 15, 0, "mul_max");

    // randomized
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
             int'($urandom_range(0, MASK)),
             (i % 3 == 0) ? int'($urandom_range(1, N)) : 0,
             $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
